ex_csa_accum_pipe: RTL and testbench

//  Multi-beat carry-save accumulator. Takes up to three WIDTH-bit operands per beat
//  and keeps the running total in redundant sum/carry form, so accumulating costs no

---
 rtl/ex_csa_accum_pipe_if.sv | 26 ++
 rtl/ex_csa_accum_pipe.sv | 130 +++++++++++++
 tb/tb_ex_csa_accum_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ex_csa_accum_pipe_if.sv
// Operand-beat / result handshake bundle for the carry-save accumulator.
// The master drives operand beats and consumes results; the slave is the accumulator.
interface ex_csa_accum_pipe_if #(
   parameter int WIDTH = 64
);
   logic             inValid;
   logic             inReady;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [WIDTH-1:0] inC;
   logic             inLast;
   logic             outValid;
   logic             outReady;
   logic [WIDTH-1:0] outSum;
   logic [15:0]      outBeats;

   modport master (
      output inValid, inA, inB, inC, inLast, outReady,
      input  inReady, outValid, outSum, outBeats
   );

   modport slave (
      input  inValid, inA, inB, inC, inLast, outReady,
      output inReady, outValid, outSum, outBeats
   );
endinterface

// File: rtl/ex_csa_accum_pipe.sv
// Multi-beat carry-save accumulator: three operands per beat folded into a redundant
// sum/carry pair, resolved at the end by a chunked carry-propagate add.
module ex_csa_accum_pipe #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input logic               clock,
   input logic               reset,
   ex_csa_accum_pipe_if.slave bus
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = $clog2(NCH + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, OUTPUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] accS_q, accS_d;
   logic [WIDTH-1:0] accC_q, accC_d;
   logic [WIDTH-1:0] outSum_q, outSum_d;
   logic [15:0]      beats_q, beats_d;
   logic [15:0]      outBeats_q, outBeats_d;
   logic [KW-1:0]    k_q, k_d;
   logic             cin_q, cin_d;
   logic             outValid_q, outValid_d;

   logic             inReady;
   logic             accept;
   logic [WIDTH-1:0] p, q, s1, c1, s2, c2;
   int               shamt;
   logic [WIDTH-1:0] sShift, cShift, chunkMask, chunkBits;
   logic [CHUNK:0]   chunkSum;

   assign inReady = (state_q == IDLE) || (state_q == ACCUM);
   assign accept  = bus.inValid && inReady;

   // Beat operands go through a 3:2 stage, then a 4:2 stage built from two more 3:2s.
   assign p  = bus.inA ^ bus.inB ^ bus.inC;
   assign q  = ((bus.inA & bus.inB) | (bus.inA & bus.inC) | (bus.inB & bus.inC)) << 1;
   assign s1 = p ^ q ^ accS_q;
   assign c1 = ((p & q) | (p & accS_q) | (q & accS_q)) << 1;
   assign s2 = s1 ^ c1 ^ accC_q;
   assign c2 = ((s1 & c1) | (s1 & accC_q) | (c1 & accC_q)) << 1;

   assign shamt     = int'(k_q) * CHUNK;
   assign sShift    = accS_q >> shamt;
   assign cShift    = accC_q >> shamt;
   assign chunkSum  = {1'b0, sShift[CHUNK-1:0]} + {1'b0, cShift[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, cin_q};
   assign chunkMask = WIDTH'({CHUNK{1'b1}}) << shamt;
   assign chunkBits = WIDTH'(chunkSum[CHUNK-1:0]) << shamt;

   // k_q == NCH is a settling step after the last chunk, giving the NCH+1 cycle latency.
   always_comb begin
      state_d    = state_q;
      accS_d     = accS_q;
      accC_d     = accC_q;
      outSum_d   = outSum_q;
      beats_d    = beats_q;
      outBeats_d = outBeats_q;
      k_d        = k_q;
      cin_d      = cin_q;
      outValid_d = outValid_q;
      case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               accS_d  = s2;
               accC_d  = c2;
               beats_d = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
               if (bus.inLast) begin
                  state_d = RESOLVE;
                  k_d     = '0;
                  cin_d   = 1'b0;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         RESOLVE: begin
            if (k_q == KW'(NCH)) begin
               state_d    = OUTPUT;
               outValid_d = 1'b1;
               outBeats_d = beats_q;
            end else begin
               outSum_d = (outSum_q & ~chunkMask) | chunkBits;
               cin_d    = chunkSum[CHUNK];
               k_d      = k_q + KW'(1);
            end
         end
         OUTPUT: begin
            if (bus.outReady) begin
               state_d    = IDLE;
               outValid_d = 1'b0;
               accS_d     = '0;
               accC_d     = '0;
               beats_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         accS_q     <= '0;
         accC_q     <= '0;
         outSum_q   <= '0;
         beats_q    <= '0;
         outBeats_q <= '0;
         k_q        <= '0;
         cin_q      <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         accS_q     <= accS_d;
         accC_q     <= accC_d;
         outSum_q   <= outSum_d;
         beats_q    <= beats_d;
         outBeats_q <= outBeats_d;
         k_q        <= k_d;
         cin_q      <= cin_d;
         outValid_q <= outValid_d;
      end
   end

   assign bus.inReady  = inReady;
   assign bus.outValid = outValid_q;
   assign bus.outSum   = outSum_q;
   assign bus.outBeats = outBeats_q;
endmodule

// File: tb/tb_ex_csa_accum_pipe.sv
// Directed bench for the carry-save accumulator: latency, wrap, long streams,
// output back-pressure, mid-resolve reset and back-to-back transactions.
module tb_ex_csa_accum_pipe;
   logic clock;
   logic reset;
   int   nAsserts;
   int   nFails;

   ex_csa_accum_pipe_if #(.WIDTH(64)) bus ();

   ex_csa_accum_pipe #(.WIDTH(64), .CHUNK(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one beat and holds it until the edge that accepts it; returns #1 after that edge.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic last);
      int n;
      bus.inA     = a;
      bus.inB     = b;
      bus.inC     = c;
      bus.inLast  = last;
      bus.inValid = 1'b1;
      n = 0;
      while (!bus.inReady && n < 30) begin
         @(posedge clock);
         #1;
         n++;
      end
      checkOutput("beat ready", bus.inReady, 1);
      @(posedge clock);
      #1;
      bus.inValid = 1'b0;
      bus.inLast  = 1'b0;
   endtask

   task automatic checkResult(input string tag, input logic [63:0] expSum, input logic [15:0] expBeats);
      int   n;
      logic oldReady;
      n = 0;
      while (!bus.outValid && n < 30) begin
         @(posedge clock);
         #1;
         n++;
      end
      checkOutput({tag, " valid"}, bus.outValid, 1);
      checkOutput({tag, " sum"}, bus.outSum, expSum);
      checkOutput({tag, " beats"}, 64'(bus.outBeats), 64'(expBeats));
      oldReady     = bus.outReady;
      bus.outReady = 1'b1;
      @(posedge clock);
      #1;
      bus.outReady = oldReady;
      checkOutput({tag, " drained"}, bus.outValid, 0);
   endtask

   initial begin
      int gap;
      nAsserts     = 0;
      nFails       = 0;
      reset        = 1'b1;
      bus.inValid  = 1'b0;
      bus.inA      = '0;
      bus.inB      = '0;
      bus.inC      = '0;
      bus.inLast   = 1'b0;
      bus.outReady = 1'b0;

      #2;
      checkOutput("reset outValid", bus.outValid, 0);
      checkOutput("reset outSum", bus.outSum, 0);
      checkOutput("reset outBeats", 64'(bus.outBeats), 0);
      checkOutput("reset inReady", bus.inReady, 1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] single beat latency");
      applyStimulus(64'd1, 64'd2, 64'd3, 1'b1);
      repeat (4) begin
         @(posedge clock);
         #1;
      end
      checkOutput("t1 not yet valid", bus.outValid, 0);
      checkOutput("t1 busy", bus.inReady, 0);
      @(posedge clock);
      #1;
      checkOutput("t1 valid at 5", bus.outValid, 1);
      checkResult("t1", 64'd6, 16'd1);

      $display("[TB] wrap and cross-chunk carry");
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
      checkResult("t2 wrap", 64'd0, 16'd1);
      applyStimulus(64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
      checkResult("t2 carry", 64'h1_0000_0000, 16'd1);

      $display("[TB] 100-beat streams");
      for (int i = 0; i < 100; i++)
         applyStimulus(64'(i), 64'(2 * i), 64'(3 * i), i == 99);
      checkResult("t3 dense", 64'd29700, 16'd100);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(64'(i), 64'(2 * i), 64'(3 * i), i == 99);
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clock);
            #1;
         end
      end
      checkResult("t3 gaps", 64'd29700, 16'd100);

      $display("[TB] output back-pressure");
      applyStimulus(64'd4, 64'd5, 64'd6, 1'b1);
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4 hold valid", bus.outValid, 1);
         checkOutput("t4 hold sum", bus.outSum, 64'd15);
         checkOutput("t4 hold beats", 64'(bus.outBeats), 64'd1);
         checkOutput("t4 hold ready", bus.inReady, 0);
         bus.inValid = (i % 2) == 0;
         bus.inA     = 64'd99;
         bus.inLast  = 1'b1;
         @(posedge clock);
         #1;
      end
      bus.inValid = 1'b0;
      bus.inLast  = 1'b0;
      checkResult("t4", 64'd15, 16'd1);
      applyStimulus(64'd2, 64'd0, 64'd0, 1'b1);
      checkResult("t4 after", 64'd2, 16'd1);

      $display("[TB] reset during resolve");
      applyStimulus(64'd10, 64'd20, 64'd30, 1'b1);
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t5 outValid", bus.outValid, 0);
      checkOutput("t5 inReady", bus.inReady, 1);
      checkOutput("t5 outSum", bus.outSum, 0);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      applyStimulus(64'd7, 64'd0, 64'd0, 1'b1);
      checkResult("t5 next", 64'd7, 16'd1);

      $display("[TB] back-to-back");
      bus.outReady = 1'b1;
      applyStimulus(64'd5, 64'd5, 64'd5, 1'b1);
      checkResult("t6 first", 64'd15, 16'd1);
      applyStimulus(64'd1, 64'd1, 64'd1, 1'b1);
      checkResult("t6 second", 64'd3, 16'd1);
      bus.outReady = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end
endmodule
